// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine holding the HI/LO
// registers. Shift-add multiply and restoring divide run on unsigned
// magnitudes, one bit per clock; a final FIX cycle restores signs and
// writes HI/LO. MTHI/MTLO write HI/LO directly from src_a.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0]    OP_MULT  = 3'b000;
    localparam logic [2:0]    OP_MULTU = 3'b001;
    localparam logic [2:0]    OP_DIV   = 3'b010;
    localparam logic [2:0]    OP_DIVU  = 3'b011;
    localparam logic [2:0]    OP_MTHI  = 3'b100;
    localparam logic [2:0]    OP_MTLO  = 3'b101;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  ONE_W    = W'(1);
    localparam logic [2*W-1:0] ONE_2W  = (2 * W)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Magnitude of an operand; only signed ops with a set sign bit negate.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        logic signed [W-1:0] sv;
        sv = v;
        return (is_signed && sv < 0) ? (~v + ONE_W) : v;
    endfunction

    // Conditional two's-complement negation for quotient/remainder.
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    // Conditional two's-complement negation for the double-width product.
    function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] v, input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  work_q, work_d;   // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]    opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic            neg_lo_q, neg_lo_d; // product / quotient must be negated
    logic            neg_hi_q, neg_hi_d; // remainder must be negated
    logic            is_div_q, is_div_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            signed_op;
    logic [W:0]      mul_sum;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  prod_fix;

    // Per-iteration datapath: shift-add step and restoring-divide trial subtraction.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : {(W + 1){1'b0}});
        div_trial = work_q[2*W-1:W-1] - {1'b0, opnd_q};
        prod_fix  = cond_neg_2w(work_q, neg_lo_q);
    end

    // Next-state and register update logic for the control FSM and HI/LO.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            work_d   = {{W{1'b0}}, magnitude(src_b, signed_op)};
                            opnd_d   = magnitude(src_a, signed_op);
                            neg_lo_d = signed_op && (src_a[W-1] ^ src_b[W-1]);
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            cnt_d    = '0;
                            dbz_d    = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == '0) begin
                                // No iteration: flag it and pulse done, HI/LO untouched.
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                work_d   = {{W{1'b0}}, magnitude(src_a, signed_op)};
                                opnd_d   = magnitude(src_b, signed_op);
                                neg_lo_d = signed_op && (src_a[W-1] ^ src_b[W-1]);
                                neg_hi_d = signed_op && src_a[W-1];
                                is_div_d = 1'b1;
                                cnt_d    = '0;
                                dbz_d    = 1'b0;
                                state_d  = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                work_d = {mul_sum, work_q[W-1:1]};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                // Remainder stays below the divisor, so W bits hold an accepted trial.
                if (!div_trial[W]) work_d = {div_trial[W-1:0], work_q[W-2:0], 1'b1};
                else               work_d = {work_q[2*W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = cond_neg_w(work_q[W-1:0], neg_lo_q);
                    hi_d = cond_neg_w(work_q[2*W-1:W], neg_hi_q);
                end else begin
                    lo_d = prod_fix[W-1:0];
                    hi_d = prod_fix[2*W-1:W];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear of everything.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic        clk;
    logic        reset_b;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int   n_cmp;
    int   n_bad;
    logic dbz_at_start;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a MULT/DIV, follow it to done; ends on the negedge of the done cycle.
    // inj > 0 pulses a DIVU 9/3 start in that busy cycle.
    task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input int inj);
        logic [31:0] h0;
        logic [31:0] l0;
        int          bc;
        bit          seen;
        bit          unstable;
        bit          overlap;
        @(negedge clk);
        h0 = hi; l0 = lo;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dbz_at_start = div_by_zero;
        bc = 0; seen = 0; unstable = 0; overlap = 0;
        for (int i = 1; i <= 60; i++) begin
            if (done) begin
                seen = 1;
                if (busy) overlap = 1;
                break;
            end
            if (busy) bc++;
            if (hi !== h0 || lo !== l0) unstable = 1;
            if (i == inj) begin
                op = OP_DIVU; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " busy_cycles"}, 64'(bc), 64'd33);
        check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, " hilo_stable"}, 64'(unstable), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    // Single-edge MTHI/MTLO or reserved op; ends one cycle after the start edge.
    task automatic run_short(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        op = o; src_a = a; src_b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0; dbz_at_start = 1'b0;
        reset_b = 1'b0; start = 1'b0; op = 3'b0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        reset_b = 1'b1;

        run_long("mult", OP_MULT, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        @(negedge clk);
        check("mult done_pulse", 64'(done), 64'd0);
        run_long("multu", OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0);
        run_long("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_long("divu", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0);
        run_long("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        // MTHI / MTLO preload
        run_short(OP_MTHI, 32'hAAAA0000);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        check("mthi hi", 64'(hi), 64'hAAAA0000);
        check("mthi lo_kept", 64'(lo), 64'h80000000);
        run_short(OP_MTLO, 32'h0000BBBB);
        check("mtlo lo", 64'(lo), 64'h0000BBBB);
        check("mtlo hi_kept", 64'(hi), 64'hAAAA0000);

        // Reserved op must not disturb anything
        run_short(OP_RSVD, 32'h55555555);
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd done", 64'(done), 64'd0);
        check("rsvd hi", 64'(hi), 64'hAAAA0000);
        check("rsvd lo", 64'(lo), 64'h0000BBBB);

        // Divide by zero
        @(negedge clk);
        op = OP_DIV; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dbz done", 64'(done), 64'd1);
        check("dbz flag", 64'(div_by_zero), 64'd1);
        check("dbz busy", 64'(busy), 64'd0);
        check("dbz hi", 64'(hi), 64'hAAAA0000);
        check("dbz lo", 64'(lo), 64'h0000BBBB);
        @(negedge clk);
        check("dbz done_pulse", 64'(done), 64'd0);
        check("dbz flag_hold", 64'(div_by_zero), 64'd1);
        check("dbz busy_after", 64'(busy), 64'd0);

        run_long("multu_small", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);
        check("multu_small dbz_clr_at_start", 64'(dbz_at_start), 64'd0);
        check("multu_small dbz", 64'(div_by_zero), 64'd0);

        // Start while busy is ignored, then MTHI in the done cycle
        run_long("multu_inj", OP_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5);
        op = OP_MTHI; src_a = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mt_in_done hi", 64'(hi), 64'h12345678);
        check("mt_in_done lo", 64'(lo), 64'd0);
        check("mt_in_done no_done", 64'(done), 64'd0);
        check("mt_in_done busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        op = OP_MULT; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst busy", 64'(busy), 64'd1);
        #2 reset_b = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst done", 64'(done), 64'd0);
        check("async_rst hi", 64'(hi), 64'd0);
        check("async_rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        run_long("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        @(negedge clk);
        check("divu_after_rst done_pulse", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
